// File: rtl/one2three_pkg.sv
// -----------------------------------------------------------------------------
// one2three_pkg
// Shared constants and types for the one2three 1-to-3 beat router.
//   DEST_W     : width of the destination field carried in the beat MSBs
//   FIFO_DEPTH : entries per output FIFO (skid2)
//   CNT_W      : width of a FIFO occupancy count (0..FIFO_DEPTH)
//   dest_e     : destination codes; DEST_INVALID beats are discarded
// -----------------------------------------------------------------------------
package one2three_pkg;

    localparam int DEST_W     = 2;
    localparam int FIFO_DEPTH = 2;
    localparam int CNT_W      = 2;

    typedef enum logic [DEST_W-1:0] {
        DEST_OUT1    = 2'd0,
        DEST_OUT2    = 2'd1,
        DEST_OUT3    = 2'd2,
        DEST_INVALID = 2'd3
    } dest_e;

endpackage

// File: rtl/one2three_skid2.sv
// -----------------------------------------------------------------------------
// skid2
// Two-entry FIFO used as the per-output buffer of one2three.
// Ports:
//   clk, reset : clock and synchronous active-high reset (clears occupancy)
//   push, din  : write request and write data
//   pop        : remove the head entry (ignored when empty)
//   head       : current head entry (valid when count != 0)
//   count      : occupancy, 0..2
//   overflow   : pulse; a push was refused because the FIFO was full and
//                no pop freed a slot in the same cycle
// Storage registers carry no reset; only the occupancy count is reset.
// -----------------------------------------------------------------------------
module skid2
    import one2three_pkg::*;
#(
    parameter int WIDTH = 40
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count,
    output logic             overflow
);

    logic [WIDTH-1:0] entry0;
    logic [WIDTH-1:0] entry1;
    logic             full;
    logic             do_pop;
    logic             push_ok;
    logic [CNT_W-1:0] wr_slot;

    assign full    = (count == CNT_W'(FIFO_DEPTH));
    assign do_pop  = pop && (count != '0);
    // A pop in the same cycle frees the slot a full-FIFO push needs.
    assign push_ok = push && (!full || do_pop);
    assign overflow = push && full && !do_pop;
    // Write slot is the occupancy left after this cycle's pop.
    assign wr_slot = count - CNT_W'(do_pop);
    assign head    = entry0;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(push_ok) - CNT_W'(do_pop);
        end
    end

    // The later write to entry0 wins when a push lands in the slot a pop
    // just vacated.
    always_ff @(posedge clk) begin
        if (do_pop) begin
            entry0 <= entry1;
        end
        if (push_ok) begin
            if (wr_slot == '0) begin
                entry0 <= din;
            end else begin
                entry1 <= din;
            end
        end
    end

endmodule

// File: rtl/one2three.sv
// -----------------------------------------------------------------------------
// one2three
// Routes each input beat to one of three outputs by its 2-bit destination
// field din[WIDTH-1:WIDTH-2] (0/1/2 -> output 1/2/3, 3 -> discarded), through
// a 2-entry skid2 FIFO per output.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   vdin, din           : input beat valid / data
//   pause1..3           : downstream stall per output
//   vdout1..3, dout1..3 : output beat valid / data (din passed unmodified)
//   pnc                 : upstream stall request (combinational; upstream
//                         registers it, so the FIFOs leave one beat of slack)
//   ovf                 : sticky flag, a beat was lost to a full FIFO
//   drop_cnt            : saturating count of destination-3 beats; present
//                         only when ONE2THREE_DROP_CNT_EN is defined
// -----------------------------------------------------------------------------
module one2three
    import one2three_pkg::*;
#(
    parameter int WIDTH = 40
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             vdin,
    input  logic [WIDTH-1:0] din,
    input  logic             pause1,
    input  logic             pause2,
    input  logic             pause3,
    output logic             vdout1,
    output logic             vdout2,
    output logic             vdout3,
    output logic [WIDTH-1:0] dout1,
    output logic [WIDTH-1:0] dout2,
    output logic [WIDTH-1:0] dout3,
    output logic             pnc,
    output logic             ovf
`ifdef ONE2THREE_DROP_CNT_EN
    ,
    output logic [7:0]       drop_cnt
`endif
);

    dest_e            dest;
    logic [2:0]       pause;
    logic [2:0]       push;
    logic [2:0]       pop;
    logic [2:0]       ovf_hit;
    logic [WIDTH-1:0] head  [3];
    logic [CNT_W-1:0] count [3];

    assign dest  = dest_e'(din[WIDTH-1 -: DEST_W]);
    assign pause = {pause3, pause2, pause1};

    for (genvar i = 0; i < 3; i++) begin : g_fifo
        assign push[i] = vdin && (dest == dest_e'(DEST_W'(i)));
        assign pop[i]  = (count[i] != '0) && !pause[i];

        skid2 #(
            .WIDTH(WIDTH)
        ) u_fifo (
            .clk      (clk),
            .reset    (reset),
            .push     (push[i]),
            .pop      (pop[i]),
            .din      (din),
            .head     (head[i]),
            .count    (count[i]),
            .overflow (ovf_hit[i])
        );
    end

    assign vdout1 = pop[0];
    assign vdout2 = pop[1];
    assign vdout3 = pop[2];
    assign dout1  = head[0];
    assign dout2  = head[1];
    assign dout3  = head[2];

    // Stall when a FIFO could not absorb the one extra beat that arrives
    // before upstream sees the registered pnc.
    always_comb begin
        pnc = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if ((count[i] == CNT_W'(FIFO_DEPTH)) ||
                ((count[i] == CNT_W'(1)) && pause[i])) begin
                pnc = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf <= 1'b0;
        end else if (|ovf_hit) begin
            ovf <= 1'b1;
        end
    end

`ifdef ONE2THREE_DROP_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt <= 8'd0;
        end else if (vdin && (dest == DEST_INVALID) && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_one2three.sv
// -----------------------------------------------------------------------------
// tb_one2three
// Directed bench for one2three. Each beat the model accepts is queued per
// output; queue heads are compared against the DUT outputs when they are
// expected to appear. Works with or without ONE2THREE_DROP_CNT_EN.
// -----------------------------------------------------------------------------
module tb_one2three;

    localparam int WIDTH = 40;

    logic             clk = 1'b0;
    logic             reset;
    logic             vdin;
    logic [WIDTH-1:0] din;
    logic             pause1, pause2, pause3;
    logic             vdout1, vdout2, vdout3;
    logic [WIDTH-1:0] dout1, dout2, dout3;
    logic             pnc;
    logic             ovf;
`ifdef ONE2THREE_DROP_CNT_EN
    logic [7:0]       drop_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    logic [WIDTH-1:0] sb [3][$];
    logic             exp_ovf;
    int               exp_drop;

    always #5 clk = ~clk;

    one2three #(
        .WIDTH(WIDTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .vdin     (vdin),
        .din      (din),
        .pause1   (pause1),
        .pause2   (pause2),
        .pause3   (pause3),
        .vdout1   (vdout1),
        .vdout2   (vdout2),
        .vdout3   (vdout3),
        .dout1    (dout1),
        .dout2    (dout2),
        .dout3    (dout3),
        .pnc      (pnc),
        .ovf      (ovf)
`ifdef ONE2THREE_DROP_CNT_EN
        ,
        .drop_cnt (drop_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 3; i++) sb[i].delete();
        exp_ovf  = 1'b0;
        exp_drop = 0;
    endtask

    // One clock cycle: drive inputs, check outputs mid-cycle, update model.
    task automatic cyc(input logic v, input logic [1:0] d, input logic [2:0] p);
        logic [WIDTH-3:0] pl;
        logic [WIDTH-1:0] data;
        logic             e_pnc;
        logic             ev;
        logic [2:0]       vd;
        logic [WIDTH-1:0] dd [3];
        pl   = (WIDTH-2)'({$urandom(), $urandom()});
        data = {d, pl};
        vdin   = v;
        din    = data;
        pause1 = p[0];
        pause2 = p[1];
        pause3 = p[2];
        @(negedge clk);
        e_pnc = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (sb[i].size() == 2 || (sb[i].size() == 1 && p[i])) e_pnc = 1'b1;
        end
        chk("pnc", 64'(pnc), 64'(e_pnc));
        chk("ovf", 64'(ovf), 64'(exp_ovf));
`ifdef ONE2THREE_DROP_CNT_EN
        chk("drop_cnt", 64'(drop_cnt), 64'(exp_drop));
`endif
        vd    = {vdout3, vdout2, vdout1};
        dd[0] = dout1;
        dd[1] = dout2;
        dd[2] = dout3;
        for (int i = 0; i < 3; i++) begin
            ev = (sb[i].size() > 0) && !p[i];
            chk($sformatf("vdout%0d", i + 1), 64'(vd[i]), 64'(ev));
            if (ev) begin
                chk($sformatf("dout%0d", i + 1), 64'(dd[i]), 64'(sb[i][0]));
                void'(sb[i].pop_front());
            end
        end
        if (v) begin
            if (d == 2'd3) begin
                if (exp_drop < 255) exp_drop++;
            end else if (sb[d].size() < 2) begin
                sb[d].push_back(data);
            end else begin
                exp_ovf = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Reset cycle with a concurrent beat that must be ignored.
    task automatic do_reset(input logic v, input logic [1:0] d);
        reset = 1'b1;
        vdin  = v;
        din   = {d, 38'h15_5555_5555};
        @(posedge clk);
        #1;
        reset = 1'b0;
        vdin  = 1'b0;
        clear_model();
    endtask

    initial begin
        reset  = 1'b1;
        vdin   = 1'b0;
        din    = '0;
        pause1 = 1'b0;
        pause2 = 1'b0;
        pause3 = 1'b0;
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // reset state
        cyc(1'b0, 2'd0, 3'b000);

        // consecutive routing to outputs 1,2,3,1
        cyc(1'b1, 2'd0, 3'b000);
        cyc(1'b1, 2'd1, 3'b000);
        cyc(1'b1, 2'd2, 3'b000);
        cyc(1'b1, 2'd0, 3'b000);
        cyc(1'b0, 2'd0, 3'b000);
        cyc(1'b0, 2'd0, 3'b000);

        // vdin=0 with a valid-looking destination is ignored
        cyc(1'b0, 2'd1, 3'b000);
        cyc(1'b0, 2'd0, 3'b000);

        // output 2 paused; upstream sends B before seeing pnc
        cyc(1'b1, 2'd1, 3'b010);
        cyc(1'b1, 2'd1, 3'b010);
        cyc(1'b0, 2'd0, 3'b010);
        cyc(1'b0, 2'd0, 3'b000);
        cyc(1'b0, 2'd0, 3'b000);
        cyc(1'b0, 2'd0, 3'b000);

        // FIFO 1 full, push and pop in the same cycle
        cyc(1'b1, 2'd0, 3'b001);
        cyc(1'b1, 2'd0, 3'b001);
        cyc(1'b1, 2'd0, 3'b000);
        cyc(1'b0, 2'd0, 3'b000);
        cyc(1'b0, 2'd0, 3'b000);
        cyc(1'b0, 2'd0, 3'b000);

        // destination-3 beats are discarded
`ifdef ONE2THREE_DROP_CNT_EN
        for (int n = 0; n < 300; n++) cyc(1'b1, 2'd3, 3'b000);
`else
        for (int n = 0; n < 5; n++) cyc(1'b1, 2'd3, 3'b000);
`endif
        cyc(1'b0, 2'd0, 3'b000);

        // overflow: FIFO 3 full and paused, third beat lost
        cyc(1'b1, 2'd2, 3'b100);
        cyc(1'b1, 2'd2, 3'b100);
        cyc(1'b1, 2'd2, 3'b100);
        cyc(1'b0, 2'd0, 3'b100);
        cyc(1'b0, 2'd0, 3'b000);
        cyc(1'b0, 2'd0, 3'b000);
        cyc(1'b0, 2'd0, 3'b000);

        // reset with all FIFOs full and a concurrent push
        cyc(1'b1, 2'd0, 3'b111);
        cyc(1'b1, 2'd0, 3'b111);
        cyc(1'b1, 2'd1, 3'b111);
        cyc(1'b1, 2'd1, 3'b111);
        cyc(1'b1, 2'd2, 3'b111);
        cyc(1'b1, 2'd2, 3'b111);
        do_reset(1'b1, 2'd0);
        for (int n = 0; n < 4; n++) cyc(1'b0, 2'd0, 3'b000);

        // normal operation after reset
        cyc(1'b1, 2'd1, 3'b000);
        cyc(1'b1, 2'd2, 3'b000);
        cyc(1'b0, 2'd0, 3'b000);
        cyc(1'b0, 2'd0, 3'b000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
